us_ip_rx: RTL and testbench
===========================

US_IP_RX -- requirements
Module: us_ip_rx

Interface
REQ-001 Parameter LOCAL_IP_CHECK, default 1, meaning: when 1, frames whose destination IP is neither local_ip_addr nor 255.255.255.255 are dropped.
REQ-002 Reset rx_axis_aresetn is asynchronous and active-low; clock is rx_axis_aclk.
REQ-003 Ports:
- rx_axis_aclk  in  1  clock
- rx_axis_aresetn  in  1  async active-low reset
- rx_frame_axis_tdata/tkeep/tvalid/tuser/tlast  in  64/8/1/1/1  Ethernet payload stream from the MAC RX stage; byte n of a beat is in tdata[8n+7:8n]
- recv_type  in  16  EtherType of the current frame, stable from the first input beat to tlast
- local_ip_addr  in  32  station IPv4 address
- rx_ip_axis_tdata/tkeep/tvalid/tuser/tlast  out  64/8/1/1/1  IP payload stream, with the 20-byte IPv4 header removed
- recv_src_ip_addr, recv_dst_ip_addr  out  32  header fields, MSB = first byte on the wire
- recv_protocol  out  8;  recv_ip_total_len  out  16
- recv_hdr_valid  out  1  one-cycle pulse when the header is accepted
- ip_drop_cnt  out  16  saturating count of dropped frames

Function
REQ-004 Input has no tready. tkeep is contiguous from lane 0. Only the first beat and the tlast beat may be partial.
REQ-005 A byte offset counter (6 bits) counts bytes per frame. Each byte with tkeep set gets offset = counter + lane. The counter clears on a tvalid&tlast beat.
REQ-006 Header bytes are captured by offset: 9 = protocol; 12-15 = source IP; 16-19 = destination IP; 2-3 = total length, big-endian.
REQ-007 Checksum: a 20-bit one's-complement accumulator sums header bytes. Even offsets feed bits [15:8]; odd offsets feed bits [7:0]. Carries fold back into the sum. The header is valid when the folded sum is 16'hFFFF.
REQ-008 Header checks are evaluated in the beat that contains offset 19:
- recv_type = 16'h0800
- byte 0 = 8'h45 (version 4, IHL 5; options are not supported)
- checksum valid
- destination address match, if LOCAL_IP_CHECK is set
- bytes 6-7 AND 16'h3FFF = 0 (no fragments)
REQ-009 State machine:
- HDR: consuming the header.
- PASS: header accepted; payload is forwarded.
- DROP: frame rejected; input is discarded until tlast.
- Transition HDR->PASS or HDR->DROP happens in the offset-19 beat.
- The tlast beat always returns the state to HDR.
REQ-010 If tlast arrives in HDR before offset 19, the frame is a drop (runt frame).
REQ-011 Output latency is 1 cycle, fully registered. Every output defaults to tvalid=0 and tlast=0 when not driven.
REQ-012 In the crossing beat (offset 19 is in the beat and more bytes follow it):
- tdata is shifted right by 8×(bytes remaining to offset 19 inclusive).
- tkeep is shifted right by the same byte count.
- tvalid=1, and tlast is taken from the input.
REQ-013 If the header ends exactly at a beat boundary, no output is produced for that beat. Payload begins on the next beat.
REQ-014 PASS beats pass through unchanged. rx_ip_axis_tuser is the OR of input tuser over the frame, presented on the output tlast beat.
REQ-015 No output beat is ever produced for a dropped frame.
REQ-016 Padding beyond recv_ip_total_len is forwarded unchanged; no trimming.
REQ-017 The header field outputs and recv_hdr_valid update 1 cycle after the accepting beat. The header fields hold until the next accepted header.
REQ-018 ip_drop_cnt increments by 1 per dropped frame and stops at 16'hFFFF.

Reset
REQ-019 On asynchronous assertion of reset:
- all outputs, counters and the accumulator clear to 0
- state goes to HDR
REQ-020 After deassertion, the first tvalid beat is treated as offset 0, even if reset occurred mid-frame.

Structure
REQ-021 Shared package us_udp_pkg holds:
- ETH_TYPE_IPV4 = 16'h0800
- IP_HDR_LEN = 20
- IP_VER_IHL = 8'h45
- IP_BCAST = 32'hFFFFFFFF
- the rx state enum
REQ-022 One sub-module, us_ip_csum_acc, implements per-beat one's-complement byte-lane accumulation with a fold output.

Verification
REQ-023 Scenarios:
- Valid UDP/IPv4 frame, dst = local 192.168.1.10, first input beat tkeep=8'h03 -> header is bytes 0-1, 2-9, 10-17, 18-19; payload out beat 1 tkeep=8'h3F; protocol=8'h11; recv_hdr_valid pulses once.
- Same frame with the checksum byte corrupted -> no rx_ip_axis_tvalid; ip_drop_cnt=1.
- dst=192.168.1.99 with LOCAL_IP_CHECK=1 -> drop; dst=255.255.255.255 -> pass.
- Header aligned so offset 19 is lane 7 -> no output that beat; next beat passes with tkeep=8'hFF.
- 12-byte runt frame with tlast, then a valid frame back-to-back -> first dropped; second passes intact; ip_drop_cnt increments by 1.
- Reset asserted mid-payload, then a new frame -> outputs 0 during reset; new frame parsed correctly from offset 0.

Source files
------------

// File: rtl/us_udp_pkg.sv
// Shared constants, header record and rx state encoding for the UDP/IP receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package us_udp_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam int          IP_HDR_LEN    = 20;
    localparam logic [7:0]  IP_VER_IHL    = 8'h45;
    localparam logic [31:0] IP_BCAST      = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        RX_HDR  = 2'd0,
        RX_PASS = 2'd1,
        RX_DROP = 2'd2
    } rx_state_t;

    // Header fields the receiver cares about, in wire order of importance.
    typedef struct packed {
        logic [7:0]  ver_ihl;
        logic [15:0] total_len;
        logic [15:0] frag;
        logic [7:0]  protocol;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } ip_hdr_t;

    // Number of valid bytes in a beat (tkeep is contiguous from lane 0).
    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/us_ip_csum_acc.sv
// One's-complement accumulator of IPv4 header bytes, one 64-bit beat per cycle.
// Latency: fold_sum is combinational and includes the current beat; state updates on the clock.
// Backpressure: none; accumulates every valid beat it is given.
module us_ip_csum_acc (
    input  logic        rx_axis_aclk,
    input  logic        rx_axis_aresetn,
    input  logic        beat_vld,
    input  logic        beat_clr,
    input  logic        odd_base,
    input  logic [7:0]  lane_en,
    input  logic [63:0] beat_dat,
    output logic [15:0] fold_sum
);

    logic [19:0] acc_q;
    logic [19:0] beat_sum;
    logic [19:0] acc_sum;
    logic [16:0] part_sum;
    logic [16:0] full_sum;

    // Sum enabled lanes; even header offsets are the high byte of a 16-bit word.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < 8; i++) begin
            if (lane_en[i]) begin
                if (odd_base ^ i[0]) begin
                    beat_sum = beat_sum + {12'h000, beat_dat[8*i +: 8]};
                end else begin
                    beat_sum = beat_sum + {4'h0, beat_dat[8*i +: 8], 8'h00};
                end
            end
        end
    end

    // Fold carries back into the low 16 bits (twice covers every carry case).
    always_comb begin
        acc_sum  = acc_q + beat_sum;
        part_sum = {1'b0, acc_sum[15:0]} + {13'h0000, acc_sum[19:16]};
        full_sum = {1'b0, part_sum[15:0]} + {16'h0000, part_sum[16]};
        fold_sum = full_sum[15:0];
    end

    // Keep the once-folded sum between beats; clear at end of frame.
    always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            acc_q <= '0;
        end else if (beat_clr) begin
            acc_q <= '0;
        end else if (beat_vld) begin
            acc_q <= {3'b000, part_sum};
        end
    end

endmodule

// File: rtl/us_ip_rx.sv
// IPv4 receive: parses/validates the 20-byte header and forwards the IP payload stream.
// Latency: 1 cycle, all outputs registered.
// Backpressure: none; input has no tready and output is never stalled.
module us_ip_rx
    import us_udp_pkg::*;
#(
    parameter bit LOCAL_IP_CHECK = 1'b1
) (
    input  logic        rx_axis_aclk,
    input  logic        rx_axis_aresetn,
    input  logic [63:0] rx_frame_axis_tdata,
    input  logic [7:0]  rx_frame_axis_tkeep,
    input  logic        rx_frame_axis_tvalid,
    input  logic        rx_frame_axis_tuser,
    input  logic        rx_frame_axis_tlast,
    input  logic [15:0] recv_type,
    input  logic [31:0] local_ip_addr,
    output logic [63:0] rx_ip_axis_tdata,
    output logic [7:0]  rx_ip_axis_tkeep,
    output logic        rx_ip_axis_tvalid,
    output logic        rx_ip_axis_tuser,
    output logic        rx_ip_axis_tlast,
    output logic [31:0] recv_src_ip_addr,
    output logic [31:0] recv_dst_ip_addr,
    output logic [7:0]  recv_protocol,
    output logic [15:0] recv_ip_total_len,
    output logic        recv_hdr_valid,
    output logic [15:0] ip_drop_cnt
);

    localparam logic [6:0] HDR_LAST_OFF = 7'(IP_HDR_LEN - 1);
    localparam logic [6:0] HDR_LEN7     = 7'(IP_HDR_LEN);

    rx_state_t   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        tuser_acc_q, tuser_acc_d;
    ip_hdr_t     hdr_q, hdr_cur;

    logic [3:0]  nbytes;
    logic [6:0]  cnt_end;
    logic [6:0]  hdr_rem;
    logic [2:0]  sh;
    logic        more;
    logic        in_hdr;
    logic        crossing;
    logic        frame_end;
    logic        user_frame;
    logic        dst_ok;
    logic        hdr_ok;
    logic [15:0] csum;
    logic [6:0]  lane_off [8];
    logic [7:0]  lane_en;

    logic [63:0] out_dat_d;
    logic [7:0]  out_keep_d;
    logic        out_vld_d, out_last_d, out_user_d;
    logic        hdr_vld_d, drop_d;

    // Beat bookkeeping: byte counts, header-crossing position and lane offsets.
    always_comb begin
        nbytes     = keep_count(rx_frame_axis_tkeep);
        cnt_end    = {1'b0, cnt_q} + {3'b000, nbytes};
        hdr_rem    = HDR_LEN7 - {1'b0, cnt_q};
        sh         = hdr_rem[2:0];
        more       = {3'b000, nbytes} > hdr_rem;
        in_hdr     = rx_frame_axis_tvalid && (state_q == RX_HDR);
        crossing   = in_hdr && (cnt_end > HDR_LAST_OFF);
        frame_end  = rx_frame_axis_tvalid && rx_frame_axis_tlast;
        user_frame = tuser_acc_q | rx_frame_axis_tuser;
        for (int i = 0; i < 8; i++) begin
            lane_off[i] = {1'b0, cnt_q} + 7'(i);
            lane_en[i]  = in_hdr && rx_frame_axis_tkeep[i] && (lane_off[i] <= HDR_LAST_OFF);
        end
    end

    // Merge this beat's header bytes into the fields captured so far.
    always_comb begin
        hdr_cur = hdr_q;
        for (int i = 0; i < 8; i++) begin
            if (lane_en[i]) begin
                case (lane_off[i])
                    7'd0:  hdr_cur.ver_ihl         = rx_frame_axis_tdata[8*i +: 8];
                    7'd2:  hdr_cur.total_len[15:8] = rx_frame_axis_tdata[8*i +: 8];
                    7'd3:  hdr_cur.total_len[7:0]  = rx_frame_axis_tdata[8*i +: 8];
                    7'd6:  hdr_cur.frag[15:8]      = rx_frame_axis_tdata[8*i +: 8];
                    7'd7:  hdr_cur.frag[7:0]       = rx_frame_axis_tdata[8*i +: 8];
                    7'd9:  hdr_cur.protocol        = rx_frame_axis_tdata[8*i +: 8];
                    7'd12: hdr_cur.src_ip[31:24]   = rx_frame_axis_tdata[8*i +: 8];
                    7'd13: hdr_cur.src_ip[23:16]   = rx_frame_axis_tdata[8*i +: 8];
                    7'd14: hdr_cur.src_ip[15:8]    = rx_frame_axis_tdata[8*i +: 8];
                    7'd15: hdr_cur.src_ip[7:0]     = rx_frame_axis_tdata[8*i +: 8];
                    7'd16: hdr_cur.dst_ip[31:24]   = rx_frame_axis_tdata[8*i +: 8];
                    7'd17: hdr_cur.dst_ip[23:16]   = rx_frame_axis_tdata[8*i +: 8];
                    7'd18: hdr_cur.dst_ip[15:8]    = rx_frame_axis_tdata[8*i +: 8];
                    7'd19: hdr_cur.dst_ip[7:0]     = rx_frame_axis_tdata[8*i +: 8];
                    default: ;
                endcase
            end
        end
    end

    us_ip_csum_acc u_csum (
        .rx_axis_aclk    (rx_axis_aclk),
        .rx_axis_aresetn (rx_axis_aresetn),
        .beat_vld        (rx_frame_axis_tvalid),
        .beat_clr        (frame_end),
        .odd_base        (cnt_q[0]),
        .lane_en         (lane_en),
        .beat_dat        (rx_frame_axis_tdata),
        .fold_sum        (csum)
    );

    // Header acceptance, evaluated with the bytes of the current (offset-19) beat included.
    always_comb begin
        dst_ok = !LOCAL_IP_CHECK
                 || (hdr_cur.dst_ip == local_ip_addr)
                 || (hdr_cur.dst_ip == IP_BCAST);
        hdr_ok = (recv_type == ETH_TYPE_IPV4)
                 && (hdr_cur.ver_ihl == IP_VER_IHL)
                 && (csum == 16'hFFFF)
                 && dst_ok
                 && ((hdr_cur.frag & 16'h3FFF) == 16'h0000);
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d    = state_q;
        out_dat_d  = '0;
        out_keep_d = '0;
        out_vld_d  = 1'b0;
        out_last_d = 1'b0;
        out_user_d = 1'b0;
        hdr_vld_d  = 1'b0;
        drop_d     = 1'b0;
        case (state_q)
            RX_HDR: begin
                if (crossing) begin
                    if (hdr_ok) begin
                        hdr_vld_d = 1'b1;
                        state_d   = rx_frame_axis_tlast ? RX_HDR : RX_PASS;
                        // Bytes after the header in this beat move down to lane 0.
                        if (more) begin
                            out_vld_d  = 1'b1;
                            out_dat_d  = rx_frame_axis_tdata >> {sh, 3'b000};
                            out_keep_d = rx_frame_axis_tkeep >> sh;
                            out_last_d = rx_frame_axis_tlast;
                            out_user_d = rx_frame_axis_tlast & user_frame;
                        end
                    end else begin
                        drop_d  = 1'b1;
                        state_d = rx_frame_axis_tlast ? RX_HDR : RX_DROP;
                    end
                end else if (in_hdr && rx_frame_axis_tlast) begin
                    // Frame ended before a complete header.
                    drop_d = 1'b1;
                end
            end
            RX_PASS: begin
                if (rx_frame_axis_tvalid) begin
                    out_vld_d  = 1'b1;
                    out_dat_d  = rx_frame_axis_tdata;
                    out_keep_d = rx_frame_axis_tkeep;
                    out_last_d = rx_frame_axis_tlast;
                    out_user_d = rx_frame_axis_tlast & user_frame;
                    if (rx_frame_axis_tlast) begin
                        state_d = RX_HDR;
                    end
                end
            end
            RX_DROP: begin
                if (frame_end) begin
                    state_d = RX_HDR;
                end
            end
            default: state_d = RX_HDR;
        endcase
    end

    // Per-frame counters: byte offset advances only while parsing the header.
    always_comb begin
        if (frame_end) begin
            cnt_d       = '0;
            tuser_acc_d = 1'b0;
        end else begin
            cnt_d       = in_hdr ? cnt_end[5:0] : cnt_q;
            tuser_acc_d = rx_frame_axis_tvalid ? user_frame : tuser_acc_q;
        end
    end

    // State, frame counters and header capture registers.
    always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            state_q     <= RX_HDR;
            cnt_q       <= '0;
            tuser_acc_q <= 1'b0;
            hdr_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tuser_acc_q <= tuser_acc_d;
            hdr_q       <= hdr_cur;
        end
    end

    // Registered output stream, header fields and drop counter.
    always_ff @(posedge rx_axis_aclk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            rx_ip_axis_tdata  <= '0;
            rx_ip_axis_tkeep  <= '0;
            rx_ip_axis_tvalid <= 1'b0;
            rx_ip_axis_tuser  <= 1'b0;
            rx_ip_axis_tlast  <= 1'b0;
            recv_src_ip_addr  <= '0;
            recv_dst_ip_addr  <= '0;
            recv_protocol     <= '0;
            recv_ip_total_len <= '0;
            recv_hdr_valid    <= 1'b0;
            ip_drop_cnt       <= '0;
        end else begin
            rx_ip_axis_tdata  <= out_dat_d;
            rx_ip_axis_tkeep  <= out_keep_d;
            rx_ip_axis_tvalid <= out_vld_d;
            rx_ip_axis_tuser  <= out_user_d;
            rx_ip_axis_tlast  <= out_last_d;
            recv_hdr_valid    <= hdr_vld_d;
            if (hdr_vld_d) begin
                recv_src_ip_addr  <= hdr_cur.src_ip;
                recv_dst_ip_addr  <= hdr_cur.dst_ip;
                recv_protocol     <= hdr_cur.protocol;
                recv_ip_total_len <= hdr_cur.total_len;
            end
            if (drop_d && (ip_drop_cnt != 16'hFFFF)) begin
                ip_drop_cnt <= ip_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_us_ip_rx.sv
// Self-checking bench for us_ip_rx: table of frames plus reset/runt sequences.
// Latency: expects each output beat one clock after the input beat that carries it.
// Backpressure: none modelled; input is driven back-to-back or with idle gaps.
module tb_us_ip_rx;
    import us_udp_pkg::*;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8010A;
    localparam logic [31:0] OTHER_IP = 32'hC0A80163;
    localparam logic [31:0] SRC_IP   = 32'h0A000001;

    logic        rx_axis_aclk = 1'b0;
    logic        rx_axis_aresetn = 1'b0;
    logic [63:0] rx_frame_axis_tdata = '0;
    logic [7:0]  rx_frame_axis_tkeep = '0;
    logic        rx_frame_axis_tvalid = 1'b0;
    logic        rx_frame_axis_tuser = 1'b0;
    logic        rx_frame_axis_tlast = 1'b0;
    logic [15:0] recv_type = 16'h0800;
    logic [31:0] local_ip_addr = LOCAL_IP;
    logic [63:0] rx_ip_axis_tdata;
    logic [7:0]  rx_ip_axis_tkeep;
    logic        rx_ip_axis_tvalid;
    logic        rx_ip_axis_tuser;
    logic        rx_ip_axis_tlast;
    logic [31:0] recv_src_ip_addr;
    logic [31:0] recv_dst_ip_addr;
    logic [7:0]  recv_protocol;
    logic [15:0] recv_ip_total_len;
    logic        recv_hdr_valid;
    logic [15:0] ip_drop_cnt;

    always #5 rx_axis_aclk = ~rx_axis_aclk;

    us_ip_rx #(.LOCAL_IP_CHECK(1'b1)) dut (
        .rx_axis_aclk         (rx_axis_aclk),
        .rx_axis_aresetn      (rx_axis_aresetn),
        .rx_frame_axis_tdata  (rx_frame_axis_tdata),
        .rx_frame_axis_tkeep  (rx_frame_axis_tkeep),
        .rx_frame_axis_tvalid (rx_frame_axis_tvalid),
        .rx_frame_axis_tuser  (rx_frame_axis_tuser),
        .rx_frame_axis_tlast  (rx_frame_axis_tlast),
        .recv_type            (recv_type),
        .local_ip_addr        (local_ip_addr),
        .rx_ip_axis_tdata     (rx_ip_axis_tdata),
        .rx_ip_axis_tkeep     (rx_ip_axis_tkeep),
        .rx_ip_axis_tvalid    (rx_ip_axis_tvalid),
        .rx_ip_axis_tuser     (rx_ip_axis_tuser),
        .rx_ip_axis_tlast     (rx_ip_axis_tlast),
        .recv_src_ip_addr     (recv_src_ip_addr),
        .recv_dst_ip_addr     (recv_dst_ip_addr),
        .recv_protocol        (recv_protocol),
        .recv_ip_total_len    (recv_ip_total_len),
        .recv_hdr_valid       (recv_hdr_valid),
        .ip_drop_cnt          (ip_drop_cnt)
    );

    typedef struct {
        int          first_n;
        int          pay_len;
        int          trunc;
        int          gap;
        logic [31:0] dst;
        logic [15:0] etype;
        logic [7:0]  ver;
        logic [15:0] frag;
        logic [7:0]  proto;
        bit          bad_csum;
        bit          user_err;
        bit          exp_pass;
    } vec_t;

    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [7:0]  proto;
        logic [15:0] len;
    } hdr_exp_t;

    beat_t    exp_q[$];
    hdr_exp_t hdr_q[$];
    int       n_chk = 0;
    int       n_fail = 0;
    int       exp_drops = 0;
    vec_t     tbl[12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Compare whatever the DUT presents this cycle against the scoreboard.
    task automatic monitor();
        beat_t    got;
        hdr_exp_t gh;
        if (rx_ip_axis_tvalid === 1'b1) begin
            got = '{rx_ip_axis_tdata, rx_ip_axis_tkeep, rx_ip_axis_tlast, rx_ip_axis_tuser};
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got %0h, required no output", got);
            end else begin
                chk("out_beat", 128'(got), 128'(exp_q.pop_front()));
            end
        end
        if (recv_hdr_valid === 1'b1) begin
            gh = '{recv_src_ip_addr, recv_dst_ip_addr, recv_protocol, recv_ip_total_len};
            if (hdr_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_hdr: got %0h, required no header pulse", gh);
            end else begin
                chk("hdr_fields", 128'(gh), 128'(hdr_q.pop_front()));
            end
        end
    endtask

    task automatic step();
        @(posedge rx_axis_aclk);
        @(negedge rx_axis_aclk);
        monitor();
    endtask

    function automatic vec_t mk(input int first_n, input int pay, input logic [31:0] dst, input bit pass);
        vec_t v;
        v.first_n = first_n;  v.pay_len = pay;     v.trunc = 0;     v.gap = 1;
        v.dst = dst;          v.etype = 16'h0800;  v.ver = 8'h45;   v.frag = 16'h0000;
        v.proto = 8'h11;      v.bad_csum = 1'b0;   v.user_err = 1'b0; v.exp_pass = pass;
        return v;
    endfunction

    // Build the frame bytes, drive them beat by beat and record expectations.
    task automatic send_frame(input vec_t v, input int abort_after);
        logic [7:0]  fb [0:255];
        logic [15:0] total;
        logic [15:0] ck;
        logic [8:0]  km;
        int unsigned sum;
        int          len, pos, bn, n, m;
        bit          uor;
        beat_t       e;
        total = 16'(20 + v.pay_len);
        fb[0] = v.ver;            fb[1] = 8'h00;
        fb[2] = total[15:8];      fb[3] = total[7:0];
        fb[4] = 8'h12;            fb[5] = 8'h34;
        fb[6] = v.frag[15:8];     fb[7] = v.frag[7:0];
        fb[8] = 8'h40;            fb[9] = v.proto;
        fb[10] = 8'h00;           fb[11] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            fb[12+i] = SRC_IP[8*(3-i) +: 8];
            fb[16+i] = v.dst[8*(3-i) +: 8];
        end
        sum = 0;
        for (int i = 0; i < 10; i++) sum += {16'h0, fb[2*i], fb[2*i+1]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        ck = ~sum[15:0];
        fb[10] = ck[15:8];
        fb[11] = ck[7:0];
        if (v.bad_csum) fb[10] = fb[10] ^ 8'h01;
        for (int i = 0; i < v.pay_len; i++) fb[20+i] = 8'(i * 7 + 3) ^ 8'hA5;
        len = (v.trunc != 0) ? v.trunc : 20 + v.pay_len;
        recv_type = v.etype;
        if (v.exp_pass) hdr_q.push_back('{SRC_IP, v.dst, v.proto, total});
        else if (exp_drops < 65535) exp_drops++;
        pos = 0;
        bn  = 0;
        uor = 1'b0;
        while (pos < len) begin
            n  = (bn == 0) ? ((v.first_n < len) ? v.first_n : len) : ((len - pos < 8) ? len - pos : 8);
            km = (9'd1 << n) - 9'd1;
            rx_frame_axis_tdata  = '0;
            for (int i = 0; i < n; i++) rx_frame_axis_tdata[8*i +: 8] = fb[pos+i];
            rx_frame_axis_tkeep  = km[7:0];
            rx_frame_axis_tvalid = 1'b1;
            rx_frame_axis_tlast  = (pos + n == len);
            rx_frame_axis_tuser  = v.user_err && (bn == 1);
            uor = uor | rx_frame_axis_tuser;
            m = 0;
            e = '0;
            for (int i = 0; i < n; i++) begin
                if (pos + i >= 20) begin
                    e.dat[8*m +: 8] = fb[pos+i];
                    m++;
                end
            end
            if (v.exp_pass && m > 0) begin
                km     = (9'd1 << m) - 9'd1;
                e.keep = km[7:0];
                e.last = rx_frame_axis_tlast;
                e.user = rx_frame_axis_tlast && uor;
                exp_q.push_back(e);
            end
            step();
            pos += n;
            bn++;
            if (abort_after > 0 && bn == abort_after) return;
        end
        rx_frame_axis_tvalid = 1'b0;
        rx_frame_axis_tlast  = 1'b0;
        rx_frame_axis_tuser  = 1'b0;
        rx_frame_axis_tkeep  = '0;
        rx_frame_axis_tdata  = '0;
        chk("beats_consumed", 128'(exp_q.size()), 128'(0));
        chk("hdr_consumed", 128'(hdr_q.size()), 128'(0));
        chk("drop_cnt", 128'(ip_drop_cnt), 128'(exp_drops));
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk(2, 30, LOCAL_IP, 1'b1);
        tbl[1]  = mk(2, 30, LOCAL_IP, 1'b0);  tbl[1].bad_csum = 1'b1;
        tbl[2]  = mk(2, 30, OTHER_IP, 1'b0);
        tbl[3]  = mk(2, 30, IP_BCAST, 1'b1);
        tbl[4]  = mk(4, 13, LOCAL_IP, 1'b1);  tbl[4].user_err = 1'b1;
        tbl[5]  = mk(8, 1,  LOCAL_IP, 1'b1);  tbl[5].proto = 8'h06; tbl[5].gap = 0;
        tbl[6]  = mk(4, 0,  LOCAL_IP, 1'b1);
        tbl[7]  = mk(2, 16, LOCAL_IP, 1'b0);  tbl[7].etype = 16'h86DD;
        tbl[8]  = mk(2, 16, LOCAL_IP, 1'b0);  tbl[8].ver = 8'h46;
        tbl[9]  = mk(2, 16, LOCAL_IP, 1'b0);  tbl[9].frag = 16'h2000;
        tbl[10] = mk(2, 16, LOCAL_IP, 1'b1);  tbl[10].frag = 16'h4000; tbl[10].gap = 0;
        tbl[11] = mk(1, 50, LOCAL_IP, 1'b1);

        repeat (3) step();
        chk("rst_tvalid", 128'(rx_ip_axis_tvalid), 128'(0));
        chk("rst_tlast", 128'(rx_ip_axis_tlast), 128'(0));
        chk("rst_tdata_tkeep", 128'({rx_ip_axis_tdata, rx_ip_axis_tkeep}), 128'(0));
        chk("rst_hdr_valid", 128'(recv_hdr_valid), 128'(0));
        chk("rst_drop_cnt", 128'(ip_drop_cnt), 128'(0));
        chk("rst_fields", 128'({recv_src_ip_addr, recv_dst_ip_addr, recv_protocol, recv_ip_total_len}), 128'(0));
        rx_axis_aresetn = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            send_frame(tbl[i], 0);
            repeat (tbl[i].gap) step();
        end

        // Runt frame immediately followed by a good frame.
        v = mk(2, 30, LOCAL_IP, 1'b0);
        v.trunc = 12;
        send_frame(v, 0);
        send_frame(mk(2, 30, LOCAL_IP, 1'b1), 0);
        step();

        // Reset in the middle of a payload, then a fresh frame from offset 0.
        send_frame(mk(2, 40, LOCAL_IP, 1'b1), 5);
        rx_axis_aresetn = 1'b0;
        #1;
        chk("midrst_tvalid", 128'(rx_ip_axis_tvalid), 128'(0));
        chk("midrst_tdata_tkeep", 128'({rx_ip_axis_tdata, rx_ip_axis_tkeep}), 128'(0));
        chk("midrst_drop_cnt", 128'(ip_drop_cnt), 128'(0));
        chk("midrst_fields", 128'({recv_dst_ip_addr, recv_protocol, recv_ip_total_len}), 128'(0));
        exp_q.delete();
        hdr_q.delete();
        exp_drops = 0;
        rx_frame_axis_tvalid = 1'b0;
        rx_frame_axis_tlast  = 1'b0;
        rx_frame_axis_tkeep  = '0;
        rx_frame_axis_tdata  = '0;
        rx_frame_axis_tuser  = 1'b0;
        repeat (3) step();
        rx_axis_aresetn = 1'b1;
        step();
        send_frame(mk(3, 20, IP_BCAST, 1'b1), 0);
        chk("post_rst_dst", 128'(recv_dst_ip_addr), 128'(IP_BCAST));
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
